// File: rtl/midi_note_mem_scheduler_if.sv
// Shared memory-port bundle between the processor load/store path, the note
// scheduler and the single-port data memory. The scheduler is the slave: it
// receives the processor request and drives the muxed memory port.
interface midi_note_mem_scheduler_if #(
    parameter int unsigned ADDR_W = 10
);
    // Processor side
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [15:0]       cpu_wdata;
    logic              cpu_grant;

    // Memory side (arbitrated)
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    modport master (
        output cpu_req,
        output cpu_we,
        output cpu_addr,
        output cpu_wdata,
        input  cpu_grant,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  cpu_req,
        input  cpu_we,
        input  cpu_addr,
        input  cpu_wdata,
        output cpu_grant,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/midi_note_mem_scheduler.sv
// MIDI note memory scheduler.
// Edge-detects note strobes, buffers notes in a small FIFO and writes each one
// into a circular buffer in shared memory, followed by a mailbox update of the
// head index. The processor always wins the memory port; note traffic only
// uses cycles in which cpu_req is low.
module midi_note_mem_scheduler #(
    parameter int unsigned       ADDR_W     = 10,
    parameter logic [ADDR_W-1:0] NOTE_BASE  = 10'h380,
    parameter int unsigned       NOTE_SLOTS = 32,
    parameter logic [ADDR_W-1:0] PTR_ADDR   = 10'h3FF,
    parameter int unsigned       FIFO_DEPTH = 4,
    localparam int unsigned      HEAD_W     = $clog2(NOTE_SLOTS),
    localparam int unsigned      PTR_W      = $clog2(FIFO_DEPTH),
    localparam int unsigned      CNT_W      = PTR_W + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     noteForMem,
    input  logic [15:0]              midiNoteWire,
    midi_note_mem_scheduler_if.slave bus,
    output logic [HEAD_W-1:0]        head_idx,
    output logic [CNT_W-1:0]         fifo_count,
    output logic                     overflow
);

    typedef enum logic [1:0] {
        st_idle,
        st_wr_note,
        st_wr_ptr
    } state_t;

    state_t state_q, state_d;

    logic              note_prev_q;
    logic [15:0]       fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [HEAD_W-1:0] head_q;
    logic              overflow_q;

    logic              push;
    logic              push_ok;
    logic              drop;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [15:0]       head_ext;

    logic              fsm_we;
    logic [ADDR_W-1:0] fsm_addr;
    logic [15:0]       fsm_wdata;

    // Note strobe edge detect and FIFO push/drop decisions.
    always_comb begin
        push       = noteForMem & ~note_prev_q;
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        // A pop in the same cycle frees the slot a full-FIFO push needs.
        push_ok    = push & (~fifo_full | pop);
        drop       = push & fifo_full & ~pop;
        count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    end

    // Mailbox value: head index zero-extended to the memory data width.
    always_comb begin
        head_ext               = '0;
        head_ext[HEAD_W-1:0]   = head_q;
    end

    // Next-state logic and the FSM's view of the memory port.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        fsm_we    = 1'b0;
        fsm_addr  = '0;
        fsm_wdata = '0;

        unique case (state_q)
            st_idle: begin
                if (!fifo_empty && !bus.cpu_req) begin
                    state_d = st_wr_note;
                end
            end
            st_wr_note: begin
                // Processor owns the port: hold the note until a free cycle.
                if (!bus.cpu_req) begin
                    fsm_we    = 1'b1;
                    fsm_addr  = NOTE_BASE + ADDR_W'(head_q);
                    fsm_wdata = fifo_mem_q[rd_ptr_q];
                    pop       = 1'b1;
                    state_d   = st_wr_ptr;
                end
            end
            st_wr_ptr: begin
                if (!bus.cpu_req) begin
                    fsm_we    = 1'b1;
                    fsm_addr  = PTR_ADDR;
                    fsm_wdata = head_ext;
                    state_d   = st_idle;
                end
            end
            default: begin
                state_d = st_idle;
            end
        endcase
    end

    // Port arbitration: processor has absolute priority; reset suppresses any
    // note or mailbox write the FSM would otherwise issue this cycle.
    always_comb begin
        bus.cpu_grant = bus.cpu_req;
        if (bus.cpu_req) begin
            bus.mem_we    = bus.cpu_we;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (reset) begin
            bus.mem_we    = 1'b0;
            bus.mem_addr  = '0;
            bus.mem_wdata = '0;
        end else begin
            bus.mem_we    = fsm_we;
            bus.mem_addr  = fsm_addr;
            bus.mem_wdata = fsm_wdata;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Edge-detect register, FIFO pointers/occupancy, head index, overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            note_prev_q <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            head_q      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            note_prev_q <= noteForMem;
            count_q     <= count_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                // NOTE_SLOTS is a power of two, so the natural wrap is the modulo.
                head_q   <= head_q + HEAD_W'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset needed.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            fifo_mem_q[wr_ptr_q] <= midiNoteWire;
        end
    end

    assign head_idx   = head_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule
